// File: rtl/sd_pkg.sv
// Shared helpers for the sigma-delta CIC decimator: width arithmetic and
// parameter-legality checks used at elaboration time.
package sd_pkg;

    function automatic int clog2(input int value);
        int result;
        int rest;
        result = 0;
        rest   = value - 1;
        while (rest > 0) begin
            result++;
            rest = rest >> 1;
        end
        return result;
    endfunction

    // Full-scale gain is R^ORDER, so ORDER*log2(R) bits of growth plus sign and headroom.
    function automatic int calc_cw(input int order, input int decimation);
        return order * clog2(decimation) + 2;
    endfunction

    function automatic bit is_pow2(input int value);
        return (value > 1) && ((value & (value - 1)) == 0);
    endfunction

    function automatic bit out_width_ok(input int order, input int decimation, input int out_width);
        return out_width <= order * clog2(decimation) + 1;
    endfunction

    function automatic bit params_ok(input int order, input int decimation);
        return (order >= 1) && (order <= 5) && is_pow2(decimation) && (decimation <= 256);
    endfunction

endpackage

// File: rtl/sd_cic_integrator.sv
// One CIC integrator stage: an enabled, free-wrapping CW-bit accumulator.
module sd_cic_integrator
    import sd_pkg::*;
#(
    parameter int CW = 14
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [CW-1:0] din,
    output logic [CW-1:0] acc
);

    // NOTE: sequential state uses non-blocking assignment so every stage samples
    // the pre-edge value of its neighbour.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc + din;
        end
    end

endmodule

// File: rtl/sigma_delta_cic_decimator.sv
// Decimating CIC filter for a 1-bit sigma-delta stream with a single-entry
// valid/ready output register. Optional build macro: SD_CIC_ROUND_EN.
module sigma_delta_cic_decimator
    import sd_pkg::*;
#(
    parameter int ORDER      = 3,
    parameter int DECIMATION = 16,
    parameter int OUT_WIDTH  = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    input  logic                        sdIn,
    output logic signed [OUT_WIDTH-1:0] outData,
    output logic                        outValid,
    input  logic                        outReady,
    output logic                        overrun
);

    localparam int CW  = calc_cw(ORDER, DECIMATION);
    localparam int PW  = clog2(DECIMATION);
    localparam int S   = CW - 1 - OUT_WIDTH;
    // A negative S left-aligns the comb result into a wider output word.
    localparam int SHR = (S > 0) ? S : 0;
    localparam int SHL = (S < 0) ? -S : 0;
    localparam int SW  = CW + SHL + 1;

    localparam logic signed [SW-1:0] SAT_MAX = {{(SW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [SW-1:0] SAT_MIN = {{(SW-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

    logic [CW-1:0] integ    [ORDER];
    logic [CW-1:0] stage_in [ORDER];

    for (genvar k = 0; k < ORDER; k++) begin : g_integ
        if (k == 0) begin : g_first
            assign stage_in[k] = sdIn ? CW'(1) : {CW{1'b1}};
        end else begin : g_next
            assign stage_in[k] = integ[k-1];
        end

        sd_cic_integrator #(
            .CW (CW)
        ) u_integ (
            .clk (clk),
            .rst (rst),
            .en  (en),
            .din (stage_in[k]),
            .acc (integ[k])
        );
    end

    logic [PW-1:0] phase;
    logic          decim;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase <= '0;
            decim <= 1'b0;
        end else begin
            decim <= en && (phase == PW'(DECIMATION - 1));
            if (en) begin
                phase <= phase + 1'b1;
            end
        end
    end

    logic [CW-1:0] comb_dly [ORDER];
    logic [CW-1:0] comb_in  [ORDER];
    logic [CW-1:0] comb_c;

    // NOTE: blocking assignments here are intentional: each difference feeds the
    // next stage within the same evaluation, and every output gets a value on
    // every pass so no latch is inferred.
    always_comb begin : comb_chain
        logic [CW-1:0] diff;
        diff = integ[ORDER-1];
        for (int k = 0; k < ORDER; k++) begin
            comb_in[k] = diff;
            diff       = diff - comb_dly[k];
        end
        comb_c = diff;
    end

    // NOTE: the comb delay line is a handful of flops, not a RAM, so it is reset
    // alongside the integrators to keep start-up transients deterministic.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < ORDER; k++) begin
                comb_dly[k] <= '0;
            end
        end else if (decim) begin
            for (int k = 0; k < ORDER; k++) begin
                comb_dly[k] <= comb_in[k];
            end
        end
    end

    logic signed [SW-1:0]        widened;
    logic signed [SW-1:0]        rounded;
    logic signed [SW-1:0]        scaled;
    logic signed [OUT_WIDTH-1:0] sat_data;

    assign widened = {{(SW-CW){comb_c[CW-1]}}, comb_c};

`ifdef SD_CIC_ROUND_EN
    // Half an output LSB; collapses to zero when no bits are shifted out.
    localparam logic signed [SW-1:0] ROUND_BIAS = signed'((SW'(1) << SHR) >> 1);
    assign rounded = widened + ROUND_BIAS;
`else
    assign rounded = widened;
`endif

    assign scaled = (rounded >>> SHR) <<< SHL;

    always_comb begin
        sat_data = scaled[OUT_WIDTH-1:0];
        if (scaled > SAT_MAX) begin
            sat_data = {1'b0, {(OUT_WIDTH-1){1'b1}}};
        end else if (scaled < SAT_MIN) begin
            sat_data = {1'b1, {(OUT_WIDTH-1){1'b0}}};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            outData  <= '0;
            outValid <= 1'b0;
            overrun  <= 1'b0;
        end else if (decim) begin
            if (!outValid || outReady) begin
                outData  <= sat_data;
                outValid <= 1'b1;
            end else begin
                overrun <= 1'b1;
            end
        end else if (outValid && outReady) begin
            outValid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sigma_delta_cic_decimator.sv
// Self-checking bench for sigma_delta_cic_decimator (ORDER=3, R=16, OUT_WIDTH=16):
// table-driven stream vectors through a scoreboard plus hand-written corner sequences.
module tb_sigma_delta_cic_decimator;

    localparam int ORDER = 3;
    localparam int R     = 16;
    localparam int OW    = 16;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic                 en  = 1'b0;
    logic                 sd  = 1'b0;
    logic                 rdy = 1'b0;
    logic signed [OW-1:0] out_data;
    logic                 out_valid;
    logic                 overrun;

    always #5 clk = ~clk;

    sigma_delta_cic_decimator #(
        .ORDER      (ORDER),
        .DECIMATION (R),
        .OUT_WIDTH  (OW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .sdIn     (sd),
        .outData  (out_data),
        .outValid (out_valid),
        .outReady (rdy),
        .overrun  (overrun)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input int actual, input int expected);
        n_tests++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic check_tol(input string name, input int actual, input int expected, input int tol);
        n_tests++;
        if ((actual < expected - tol) || (actual > expected + tol)) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d +/- %0d", name, actual, expected, tol);
        end
    endtask

    // Scoreboard: expected samples queued when their last input sample is driven.
    typedef struct {
        string tag;
        int    value;
        int    tol;
        bit    known;
    } exp_t;

    exp_t sb[$];

    task automatic push(input string tag, input int value, input int tol, input bit known);
        exp_t e;
        e.tag   = tag;
        e.value = value;
        e.tol   = tol;
        e.known = known;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (rst && out_valid && rdy) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_output: got %0d, expected no sample", out_data);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (e.known) begin
                    check_tol(e.tag, int'(out_data), e.value, e.tol);
                end
            end
        end
    end

    // First-order sigma-delta modulator producing the bitstream for the PCM vector.
    int mod_acc = 0;

    function automatic bit mod_step(input int x);
        int v;
        bit b;
        v       = mod_acc + x;
        b       = (v >= 0);
        mod_acc = v - (b ? 32768 : -32768);
        return b;
    endfunction

    task automatic step(input logic e, input logic s, input logic r);
        en  = e;
        sd  = s;
        rdy = r;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        rst     = 1'b1;
        mod_acc = 0;
        sb.delete();
    endtask

    task automatic drain(input string name, input int budget);
        for (int i = 0; i < budget && sb.size() > 0; i++) begin
            step(1'b0, 1'b0, 1'b1);
        end
        check(name, sb.size(), 0);
        sb.delete();
    endtask

    typedef enum {P_ONE, P_ZERO, P_ALT, P_MOD} pat_t;

    typedef struct {
        string name;
        pat_t  pat;
        int    frames;
        bit    trans_known;
        int    t1;
        int    t2;
        int    steady;
        int    tol;
    } vec_t;

    vec_t vecs[4];

    initial begin
        // Transients for constant input follow from C(16k,3) through a third difference:
        // C = 560, 3280, 4096 -> scaled by 8 -> 4480, 26240, 32768 (saturates).
        vecs[0] = '{"const_one",  P_ONE,  8, 1'b1,  4480,  26240,  32767, 0};
        vecs[1] = '{"const_zero", P_ZERO, 8, 1'b1, -4480, -26240, -32768, 0};
        vecs[2] = '{"alternate",  P_ALT,  8, 1'b0,     0,      0,      0, 0};
        vecs[3] = '{"mod_4000",   P_MOD,  8, 1'b0,     0,      0,  16384, 2};

        rst = 1'b0;
        step(1'b0, 1'b0, 1'b1);
        check("reset_data",    int'(out_data), 0);
        check("reset_valid",   int'(out_valid), 0);
        check("reset_overrun", int'(overrun), 0);

        foreach (vecs[v]) begin
            do_reset();
            for (int n = 1; n <= vecs[v].frames * R; n++) begin
                bit b;
                case (vecs[v].pat)
                    P_ONE:   b = 1'b1;
                    P_ZERO:  b = 1'b0;
                    P_ALT:   b = (n % 2) == 1;
                    default: b = mod_step(16384);
                endcase
                if (n % R == 0) begin
                    int k;
                    k = n / R;
                    if (k == 1)
                        push({vecs[v].name, "_k1"}, vecs[v].t1, vecs[v].tol, vecs[v].trans_known);
                    else if (k == 2)
                        push({vecs[v].name, "_k2"}, vecs[v].t2, vecs[v].tol, vecs[v].trans_known);
                    else
                        push({vecs[v].name, "_steady"}, vecs[v].steady, vecs[v].tol,
                             vecs[v].trans_known || (k > ORDER));
                end
                step(1'b1, b, 1'b1);
            end
            drain({vecs[v].name, "_drain"}, 10);
            check({vecs[v].name, "_overrun"}, int'(overrun), 0);
        end

        // Backpressure: first sample held, second dropped with sticky overrun.
        do_reset();
        for (int i = 1; i <= 40; i++) begin
            step(1'b1, 1'b1, 1'b0);
            if (i == 32) check("bp_overrun_before_drop", int'(overrun), 0);
            if (i == 33) check("bp_overrun_at_drop", int'(overrun), 1);
        end
        check("bp_valid_held",   int'(out_valid), 1);
        check("bp_data_held",    int'(out_data), 4480);
        check("bp_overrun_held", int'(overrun), 1);
        push("bp_first",  4480, 0, 1'b1);
        push("bp_next",  32767, 0, 1'b1);
        for (int i = 41; i <= 48; i++) begin
            step(1'b1, 1'b1, 1'b1);
        end
        drain("bp_drain", 10);
        check("bp_overrun_sticky", int'(overrun), 1);

        // Load and consume on the same edge: load wins, no overrun.
        do_reset();
        push("simul_first",   4480, 0, 1'b1);
        push("simul_second", 26240, 0, 1'b1);
        for (int i = 1; i <= 32; i++) begin
            step(1'b1, 1'b1, 1'b0);
        end
        step(1'b0, 1'b0, 1'b1);
        check("simul_valid",   int'(out_valid), 1);
        check("simul_data",    int'(out_data), 26240);
        check("simul_overrun", int'(overrun), 0);
        drain("simul_drain", 5);
        check("consume_clears_valid", int'(out_valid), 0);

        // Asynchronous reset mid-frame with en at 1-in-4.
        do_reset();
        for (int p = 1; p <= 20; p++) begin
            step(1'b1, 1'b1, 1'b0);
            repeat (3) step(1'b0, 1'b1, 1'b0);
        end
        check("pre_rst_valid", int'(out_valid), 1);
        #3;
        rst = 1'b0;
        #1;
        check("async_rst_data",    int'(out_data), 0);
        check("async_rst_valid",   int'(out_valid), 0);
        check("async_rst_overrun", int'(overrun), 0);
        @(posedge clk);
        #4;
        rst = 1'b1;
        @(posedge clk);
        #1;
        push("post_rst_first", 4480, 0, 1'b1);
        for (int p = 1; p <= 16; p++) begin
            step(1'b1, 1'b1, 1'b1);
            if (p < 16) repeat (3) step(1'b0, 1'b1, 1'b1);
        end
        check("post_rst_not_early", int'(out_valid), 0);
        step(1'b0, 1'b1, 1'b1);
        check("post_rst_latency", int'(out_valid), 1);
        drain("post_rst_drain", 5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
